// File: rtl/bg_sprite_compositor.sv
`default_nettype none
// bg_sprite_compositor: maps VGA scan position to background/sprite RAM addresses and keys the sprite over the 2x background.
// Revision: 1.0
module bg_sprite_compositor #(
  parameter int          BG_W       = 320,
  parameter int          BG_H       = 240,
  parameter int          SPR_W      = 64,
  parameter int          SPR_H      = 64,
  parameter int          NUM_FRAMES = 4,
  parameter logic [11:0] KEY_COLOR  = 12'h0F0,
  parameter int          BG_AW      = 17,
  parameter int          SPR_AW     = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixel_tick,
  input  logic              video_on,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic [9:0]        spr_x,
  input  logic [9:0]        spr_y,
  input  logic [1:0]        frame_sel,
  input  logic              mirror,
  output logic [BG_AW-1:0]  bg_addr,
  output logic [SPR_AW-1:0] spr_addr,
  input  logic [11:0]       bg_data,
  input  logic [11:0]       spr_data,
  output logic [11:0]       rgb_out,
  output logic              rgb_valid
);

  localparam int         CW         = $clog2(SPR_W);
  localparam int         RW         = $clog2(SPR_H);
  localparam logic [1:0] LAST_FRAME = 2'(NUM_FRAMES - 1);

  if (BG_W * BG_H > (1 << BG_AW)) begin : g_bg_aw_check
    $error("BG_AW too narrow for BG_W*BG_H");
  end
  if (NUM_FRAMES * SPR_W * SPR_H > (1 << SPR_AW)) begin : g_spr_aw_check
    $error("SPR_AW too narrow for NUM_FRAMES*SPR_W*SPR_H");
  end

  logic [9:0]        sx_q, sx_d, sy_q, sy_d;
  logic [1:0]        fr_q, fr_d;
  logic              mir_q, mir_d;
  logic [BG_AW-1:0]  bg_addr_q, bg_addr_d;
  logic [SPR_AW-1:0] spr_addr_q, spr_addr_d;
  logic [11:0]       rgb_q, rgb_d;
  logic              rgb_valid_q, rgb_valid_d;
  logic              v1_q, v1_d, hit1_q, hit1_d, von1_q, von1_d;
  logic              v2_q, hit2_q, von2_q;

  logic              frame_start;
  logic [10:0]       dx, dy;
  logic              hit;
  logic [CW-1:0]     col;
  logic [BG_AW-1:0]  bg_calc;
  logic [SPR_AW-1:0] spr_calc;

  assign frame_start = pixel_tick && (pixel_x == 10'd0) && (pixel_y == 10'd0);

  // The _d shadow values are what the current pixel uses, so (0,0) sees the freshly latched state.
  always_comb begin
    sx_d  = sx_q;
    sy_d  = sy_q;
    fr_d  = fr_q;
    mir_d = mir_q;
    if (frame_start) begin
      sx_d  = spr_x;
      sy_d  = spr_y;
      fr_d  = (frame_sel > LAST_FRAME) ? LAST_FRAME : frame_sel;
      mir_d = mirror;
    end
  end

  always_comb begin
    dx       = {1'b0, pixel_x} - {1'b0, sx_d};
    dy       = {1'b0, pixel_y} - {1'b0, sy_d};
    hit      = video_on && !dx[10] && (dx < 11'(SPR_W)) && !dy[10] && (dy < 11'(SPR_H));
    col      = mir_d ? (CW'(SPR_W - 1) - dx[CW-1:0]) : dx[CW-1:0];
    bg_calc  = BG_AW'(pixel_y[9:1]) * BG_AW'(BG_W) + BG_AW'(pixel_x[9:1]);
    spr_calc = SPR_AW'(fr_d) * SPR_AW'(SPR_W * SPR_H)
             + SPR_AW'(dy[RW-1:0]) * SPR_AW'(SPR_W)
             + SPR_AW'(col);
  end

  always_comb begin
    bg_addr_d   = (pixel_tick && video_on) ? bg_calc : bg_addr_q;
    spr_addr_d  = (pixel_tick && hit) ? spr_calc : spr_addr_q;
    v1_d        = pixel_tick;
    hit1_d      = pixel_tick && hit;
    von1_d      = pixel_tick && video_on;
    rgb_valid_d = v2_q;
    rgb_d       = rgb_q;
    if (v2_q) begin
      if (!von2_q)
        rgb_d = 12'h000;
      else if (hit2_q && (spr_data != KEY_COLOR))
        rgb_d = spr_data;
      else
        rgb_d = bg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sx_q        <= '0;
      sy_q        <= '0;
      fr_q        <= '0;
      mir_q       <= 1'b0;
      bg_addr_q   <= '0;
      spr_addr_q  <= '0;
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
      v1_q        <= 1'b0;
      hit1_q      <= 1'b0;
      von1_q      <= 1'b0;
      v2_q        <= 1'b0;
      hit2_q      <= 1'b0;
      von2_q      <= 1'b0;
    end else begin
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      fr_q        <= fr_d;
      mir_q       <= mir_d;
      bg_addr_q   <= bg_addr_d;
      spr_addr_q  <= spr_addr_d;
      rgb_q       <= rgb_d;
      rgb_valid_q <= rgb_valid_d;
      v1_q        <= v1_d;
      hit1_q      <= hit1_d;
      von1_q      <= von1_d;
      v2_q        <= v1_q;
      hit2_q      <= hit1_q;
      von2_q      <= von1_q;
    end
  end

  assign bg_addr   = bg_addr_q;
  assign spr_addr  = spr_addr_q;
  assign rgb_out   = rgb_q;
  assign rgb_valid = rgb_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_bg_sprite_compositor.sv
`default_nettype none
// tb_bg_sprite_compositor: directed checks of addressing, sprite keying, frame latch and pipeline timing.
// Revision: 1.0
module tb_bg_sprite_compositor;

  logic        clk = 1'b0;
  logic        reset;
  logic        pixel_tick, video_on, mirror;
  logic [9:0]  pixel_x, pixel_y, spr_x, spr_y;
  logic [1:0]  frame_sel;
  logic [16:0] bg_addr;
  logic [13:0] spr_addr;
  logic [11:0] bg_data, spr_data, rgb_out, spr_color;
  logic        rgb_valid;

  int checks = 0;
  int errors = 0;

  logic [16:0] o_bg;
  logic [13:0] o_spr;
  logic [11:0] o_rgb;
  logic [11:0] got [8];
  int          n, first;

  always #5 clk = ~clk;

  bg_sprite_compositor #(.NUM_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .spr_x(spr_x), .spr_y(spr_y),
    .frame_sel(frame_sel), .mirror(mirror), .bg_addr(bg_addr), .spr_addr(spr_addr),
    .bg_data(bg_data), .spr_data(spr_data), .rgb_out(rgb_out), .rgb_valid(rgb_valid)
  );

  function automatic logic [11:0] bgf(input logic [16:0] a);
    return a[11:0] ^ {7'b0, a[16:12]} ^ 12'hA5A;
  endfunction

  // Registered-read RAM models
  always @(posedge clk) begin
    bg_data  <= bgf(bg_addr);
    spr_data <= spr_color;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic von,
                     output logic [16:0] obg, output logic [13:0] ospr, output logic [11:0] orgb);
    @(negedge clk);
    pixel_tick = 1'b1; pixel_x = x; pixel_y = y; video_on = von;
    @(negedge clk);
    pixel_tick = 1'b0;
    obg = bg_addr; ospr = spr_addr;
    chk("valid_t1", 32'(rgb_valid), 32'd0);
    @(negedge clk);
    chk("valid_t2", 32'(rgb_valid), 32'd0);
    @(negedge clk);
    chk("valid_t3", 32'(rgb_valid), 32'd1);
    orgb = rgb_out;
    @(negedge clk);
    chk("valid_t4", 32'(rgb_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; pixel_tick = 1'b0; video_on = 1'b0; pixel_x = '0; pixel_y = '0;
    spr_x = 10'd100; spr_y = 10'd50; frame_sel = 2'd1; mirror = 1'b0; spr_color = 12'h0F0;
    repeat (3) @(negedge clk);
    chk("rst_bg_addr", 32'(bg_addr), 32'd0);
    chk("rst_spr_addr", 32'(spr_addr), 32'd0);
    chk("rst_rgb", 32'(rgb_out), 32'd0);
    chk("rst_valid", 32'(rgb_valid), 32'd0);
    reset = 1'b0;

    pix(10'd0, 10'd0, 1'b1, o_bg, o_spr, o_rgb);
    chk("origin_bg_addr", 32'(o_bg), 32'd0);
    chk("origin_rgb", 32'(o_rgb), 32'(bgf(17'd0)));

    pix(10'd639, 10'd479, 1'b1, o_bg, o_spr, o_rgb);
    chk("max_bg_addr", 32'(o_bg), 32'd76799);
    chk("max_rgb", 32'(o_rgb), 32'(bgf(17'd76799)));
    pix(10'd2, 10'd3, 1'b1, o_bg, o_spr, o_rgb);
    chk("bg_addr_2_3", 32'(o_bg), 32'd321);

    spr_color = 12'hF00;
    pix(10'd110, 10'd60, 1'b1, o_bg, o_spr, o_rgb);
    chk("hit_bg_addr", 32'(o_bg), 32'd9655);
    chk("hit_spr_addr", 32'(o_spr), 32'd4746);
    chk("hit_rgb", 32'(o_rgb), 32'h0F00);
    spr_color = 12'h0F0;
    pix(10'd110, 10'd60, 1'b1, o_bg, o_spr, o_rgb);
    chk("key_spr_addr", 32'(o_spr), 32'd4746);
    chk("key_rgb", 32'(o_rgb), 32'(bgf(17'd9655)));

    mirror = 1'b1; spr_color = 12'hF00;
    pix(10'd0, 10'd0, 1'b1, o_bg, o_spr, o_rgb);
    chk("latch_spr_hold", 32'(o_spr), 32'd4746);
    pix(10'd110, 10'd60, 1'b1, o_bg, o_spr, o_rgb);
    chk("mirror_spr_addr", 32'(o_spr), 32'd4789);
    chk("mirror_rgb", 32'(o_rgb), 32'h0F00);
    pix(10'd164, 10'd60, 1'b1, o_bg, o_spr, o_rgb);
    chk("edge_spr_hold", 32'(o_spr), 32'd4789);
    chk("edge_rgb", 32'(o_rgb), 32'(bgf(17'd9682)));

    spr_x = 10'd300;
    pix(10'd5, 10'd10, 1'b1, o_bg, o_spr, o_rgb);
    pix(10'd110, 10'd60, 1'b1, o_bg, o_spr, o_rgb);
    chk("midframe_spr_addr", 32'(o_spr), 32'd4789);
    chk("midframe_rgb", 32'(o_rgb), 32'h0F00);

    frame_sel = 2'd3; mirror = 1'b0;
    pix(10'd0, 10'd0, 1'b1, o_bg, o_spr, o_rgb);
    pix(10'd310, 10'd60, 1'b1, o_bg, o_spr, o_rgb);
    chk("clamp_bg_addr", 32'(o_bg), 32'd9755);
    chk("clamp_spr_addr", 32'(o_spr), 32'd4746);
    chk("clamp_rgb", 32'(o_rgb), 32'h0F00);
    pix(10'd110, 10'd60, 1'b1, o_bg, o_spr, o_rgb);
    chk("moved_spr_hold", 32'(o_spr), 32'd4746);
    chk("moved_rgb", 32'(o_rgb), 32'(bgf(17'd9655)));

    pix(10'd700, 10'd500, 1'b0, o_bg, o_spr, o_rgb);
    chk("blank_bg_hold", 32'(o_bg), 32'd9655);
    chk("blank_rgb", 32'(o_rgb), 32'd0);

    // Three ticks on consecutive clocks
    @(negedge clk);
    pixel_tick = 1'b1; pixel_x = 10'd2; pixel_y = 10'd0; video_on = 1'b1;
    @(negedge clk);
    pixel_x = 10'd4;
    @(negedge clk);
    pixel_x = 10'd6;
    n = 0; first = -1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      pixel_tick = 1'b0;
      if (rgb_valid && n < 8) begin
        if (first < 0) first = i;
        got[n] = rgb_out;
        n++;
      end
    end
    chk("b2b_count", 32'(n), 32'd3);
    chk("b2b_first_slot", 32'(first), 32'd0);
    chk("b2b_rgb0", 32'(got[0]), 32'(bgf(17'd1)));
    chk("b2b_rgb1", 32'(got[1]), 32'(bgf(17'd2)));
    chk("b2b_rgb2", 32'(got[2]), 32'(bgf(17'd3)));

    // Reset one clock after a tick drops the in-flight pixel
    @(negedge clk);
    pixel_tick = 1'b1; pixel_x = 10'd8; pixel_y = 10'd0;
    @(negedge clk);
    pixel_tick = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (rgb_valid) n++;
      @(negedge clk);
    end
    chk("flush_valid_count", 32'(n), 32'd0);
    chk("flush_rgb", 32'(rgb_out), 32'd0);
    chk("flush_bg_addr", 32'(bg_addr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
